// File: rtl/pwm_generator.sv
// Fixed-period PWM generator with a double-buffered on-time.
// On-time changes land only at period boundaries, and stopping lets the current period finish first.
`timescale 1ns/1ps

module pwm_generator #(
    parameter int PERIOD_VALUE   = 2000,
    parameter int RESET_ON_VALUE = 1500,
    localparam int CW            = $clog2(PERIOD_VALUE + 1)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          enable_i,
    input  logic [CW-1:0] on_value_i,
    input  logic          load_i,
    output logic          pwm_o,
    output logic          period_start_o,
    output logic          pending_o,
    output logic [CW-1:0] active_value_o,
    output logic          running_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CW-1:0] PERIOD_CW   = CW'(PERIOD_VALUE);
    localparam logic [CW-1:0] LAST_COUNT  = CW'(PERIOD_VALUE - 1);
    localparam logic [CW-1:0] RESET_ON_CW = CW'(RESET_ON_VALUE);

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [CW-1:0] active, active_nxt;
    logic [CW-1:0] pending_value, pending_value_nxt;
    logic          pending, pending_nxt;
    logic          pwm, pwm_nxt;
    logic          period_start, period_start_nxt;
    logic [CW-1:0] load_value;
    logic          wrap;

    // Requests above one full period saturate to 100% duty.
    assign load_value = (on_value_i > PERIOD_CW) ? PERIOD_CW : on_value_i;
    assign wrap       = (state != ST_IDLE) && (count == LAST_COUNT);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_nxt         = state;
        count_nxt         = count;
        active_nxt        = active;
        pending_value_nxt = pending_value;
        pending_nxt       = pending;

        case (state)
            ST_IDLE: begin
                count_nxt = '0;
                if (load_i) begin
                    active_nxt = load_value;
                end
                if (enable_i) begin
                    state_nxt = ST_RUN;
                end
            end

            ST_RUN, ST_DRAIN: begin
                if (wrap) begin
                    // A load on the last tick bypasses the buffer and supersedes anything pending.
                    count_nxt   = '0;
                    pending_nxt = 1'b0;
                    if (load_i) begin
                        active_nxt = load_value;
                    end else if (pending) begin
                        active_nxt = pending_value;
                    end
                end else begin
                    count_nxt = count + CW'(1);
                    if (load_i) begin
                        pending_value_nxt = load_value;
                        pending_nxt       = 1'b1;
                    end
                end

                if (enable_i) begin
                    state_nxt = ST_RUN;
                end else if (state == ST_RUN) begin
                    state_nxt = ST_DRAIN;
                end else if (wrap) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end
            end

            default: begin
                state_nxt   = ST_IDLE;
                count_nxt   = '0;
                pending_nxt = 1'b0;
            end
        endcase
    end

    // Outputs are computed from next-state values so they register in step with count.
    assign period_start_nxt = (state_nxt != ST_IDLE) && (count_nxt == '0);
    assign pwm_nxt          = (state_nxt != ST_IDLE) && (count_nxt < active_nxt);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= ST_IDLE;
            count         <= '0;
            active        <= RESET_ON_CW;
            pending_value <= '0;
            pending       <= 1'b0;
            pwm           <= 1'b0;
            period_start  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state         <= state_nxt;
            count         <= count_nxt;
            active        <= active_nxt;
            pending_value <= pending_value_nxt;
            pending       <= pending_nxt;
            pwm           <= pwm_nxt;
            period_start  <= period_start_nxt;
        end
    end

    assign pwm_o          = pwm;
    assign period_start_o = period_start;
    assign pending_o      = pending;
    assign active_value_o = active;
    assign running_o      = (state == ST_RUN) || (state == ST_DRAIN);

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator: directed per-cycle expectations are queued by the
// driver and popped by an independent monitor on the falling clock edge.
`timescale 1ns/1ps

module tb_pwm_generator;

    localparam int P  = 10;
    localparam int R  = 5;
    localparam int CW = $clog2(P + 1);

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          en_r   = 1'b0;
    logic          load_r = 1'b0;
    logic [CW-1:0] val_r  = '0;
    logic          pwm, ps, pend, run;
    logic [CW-1:0] act;

    typedef struct {
        logic pwm;
        logic ps;
        logic pend;
        logic run;
        int   act;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   sample_idx = 0;

    always #5 clk = ~clk;

    pwm_generator #(
        .PERIOD_VALUE  (P),
        .RESET_ON_VALUE(R)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .enable_i      (en_r),
        .on_value_i    (val_r),
        .load_i        (load_r),
        .pwm_o         (pwm),
        .period_start_o(ps),
        .pending_o     (pend),
        .active_value_o(act),
        .running_o     (run)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s sample=%0d got=%0d expected=%0d", name, sample_idx, actual, required);
        end
    endtask

    task automatic push_exp(input logic p, input logic s, input logic pd, input logic r, input int a);
        exp_t e;
        e.pwm  = p;
        e.ps   = s;
        e.pend = pd;
        e.run  = r;
        e.act  = a;
        exp_q.push_back(e);
    endtask

    // One IDLE (or reset) cycle: outputs parked, active value as given.
    task automatic idle_cycle(input logic en, input logic ld, input int val, input int a);
        @(posedge clk);
        #1;
        en_r   = en;
        load_r = ld;
        val_r  = CW'(val);
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, a);
    endtask

    // n cycles of a running period; high/act/pend_from are the hand-derived expectations.
    task automatic period(input int n, input int high, input int a, input int pend_from,
                          input int ld1_at, input int ld1_val, input int ld2_at, input int ld2_val,
                          input int en_off_at, input int en_on_at);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == en_off_at) en_r = 1'b0;
            if (i == en_on_at)  en_r = 1'b1;
            load_r = (i == ld1_at) || (i == ld2_at);
            val_r  = (i == ld2_at) ? CW'(ld2_val) : CW'(ld1_val);
            push_exp(i < high, i == 0, (pend_from >= 0) && (i >= pend_from), 1'b1, a);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pwm",          32'(pwm),  32'(e.pwm));
                check("period_start", 32'(ps),   32'(e.ps));
                check("pending",      32'(pend), 32'(e.pend));
                check("running",      32'(run),  32'(e.run));
                check("active_value", 32'(act),  32'(e.act));
                sample_idx++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog sample=%0d got=timeout expected=finish", sample_idx);
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        // Reset held, then released into IDLE.
        idle_cycle(1'b0, 1'b0, 0, R);
        idle_cycle(1'b0, 1'b0, 0, R);
        rst = 1'b0;
        idle_cycle(1'b0, 1'b0, 0, R);
        idle_cycle(1'b1, 1'b0, 0, R);

        // Default duty, two full periods.
        period(10, 5, 5, -1, -1, 0, -1, 0, -1, -1);
        period(10, 5, 5, -1, -1, 0, -1, 0, -1, -1);
        // Load 3 at count 4: buffered, applied next period.
        period(10, 5, 5, 5, 4, 3, -1, 0, -1, -1);
        // Load 7 then 2: last value wins.
        period(10, 3, 3, 2, 1, 7, 6, 2, -1, -1);
        // Load 8 on the wrap tick: direct, never pending.
        period(10, 2, 2, -1, 9, 8, -1, 0, -1, -1);
        // Pending 4 superseded by 6 loaded on the wrap tick.
        period(10, 8, 8, 4, 3, 4, 9, 6, -1, -1);
        // Load 0: next periods are fully low but still pulse period_start.
        period(10, 6, 6, 1, 0, 0, -1, 0, -1, -1);
        period(10, 0, 0, -1, -1, 0, -1, 0, -1, -1);
        // Load 15 clamps to 10: fully high across boundaries.
        period(10, 0, 0, 6, 5, 15, -1, 0, -1, -1);
        period(10, 10, 10, -1, -1, 0, -1, 0, -1, -1);
        period(10, 10, 10, 3, 2, 5, -1, 0, -1, -1);
        // Drop enable at count 2: period completes, then IDLE.
        period(10, 5, 5, -1, -1, 0, -1, 0, 2, -1);

        // IDLE loads apply directly on the next edge, with clamping.
        idle_cycle(1'b0, 1'b0, 0, 5);
        idle_cycle(1'b0, 1'b0, 0, 5);
        idle_cycle(1'b0, 1'b1, 7, 5);
        idle_cycle(1'b0, 1'b1, 12, 7);
        idle_cycle(1'b0, 1'b1, 5, 10);
        idle_cycle(1'b1, 1'b0, 0, 5);

        // Drop at count 2, re-raise at count 6: no gap in the waveform.
        period(10, 5, 5, -1, -1, 0, -1, 0, 2, 6);
        period(10, 5, 5, -1, -1, 0, -1, 0, -1, -1);
        // Drain with a pending value: transferred at the final boundary.
        period(10, 5, 5, 4, 3, 4, -1, 0, 1, -1);
        idle_cycle(1'b0, 1'b0, 0, 4);
        idle_cycle(1'b1, 1'b0, 0, 4);

        // Partial period with a pending load, then reset mid-high-phase.
        period(3, 4, 4, 2, 1, 9, -1, 0, -1, -1);
        @(posedge clk);
        #1;
        check("pre_reset_pwm", 32'(pwm), 32'd1);
        check("pre_reset_pending", 32'(pend), 32'd1);
        #1;
        rst    = 1'b1;
        en_r   = 1'b0;
        load_r = 1'b0;
        #1;
        check("async_reset_pwm", 32'(pwm), 32'd0);
        check("async_reset_pending", 32'(pend), 32'd0);
        check("async_reset_active", 32'(act), 32'(R));
        check("async_reset_running", 32'(run), 32'd0);
        check("async_reset_period_start", 32'(ps), 32'd0);
        idle_cycle(1'b0, 1'b0, 0, R);
        rst = 1'b0;
        idle_cycle(1'b0, 1'b1, 6, R);
        idle_cycle(1'b0, 1'b0, 0, 6);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
- Transmit-side counterpart of the PWM analyzer: produces a fixed-period PWM waveform whose on-time, in clock ticks, is set by a double-buffered input value.
- On-time updates are accepted at any time but take effect only at a period boundary, so no period is ever truncated.
- Stopping is graceful: the current period completes before the output parks low.
- Drives the pin that the analyzer side samples; the reset on-time sits between the analyzer's LOW and HIGH thresholds.

Parameters:
- PERIOD_VALUE, 2000, clock ticks per PWM period (≥2).
- RESET_ON_VALUE, 1500, active on-time after reset (≤ PERIOD_VALUE).
- CW (derived, localparam), $clog2(PERIOD_VALUE+1), width of count and on-time values.

Ports:
- clock_i  in  1  clock; all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  run request.
- on_value_i  in  CW  requested on-time in ticks.
- load_i  in  1  one-cycle strobe; samples on_value_i.
- pwm_o  out  1  PWM output, registered.
- period_start_o  out  1  one-cycle pulse on the first tick of each period.
- pending_o  out  1  a loaded value is waiting for the next period boundary.
- active_value_o  out  CW  on-time used by the current/next period.
- running_o  out  1  high in RUN and DRAIN.

Behaviour:
- Reset (async, reset_i=1):
  - State IDLE, count=0, pending register=0.
  - pwm_o=0, period_start_o=0, pending_o=0, running_o=0.
  - active_value_o=RESET_ON_VALUE.
  - Reset mid-period aborts immediately; pwm_o falls asynchronously.
- Clamp: any loaded value > PERIOD_VALUE is stored as PERIOD_VALUE (100% duty). A value of 0 means pwm_o stays low for the whole period.
- IDLE:
  - pwm_o=0, count held at 0.
  - load_i writes the clamped value directly to active_value_o on the next edge; pending_o stays 0.
  - enable_i=1 → RUN.
- RUN:
  - The first cycle after entry has count=0 and period_start_o=1.
  - count increments each cycle, 0..PERIOD_VALUE-1, then wraps to 0. period_start_o=1 on every cycle where count=0.
  - pwm_o=1 exactly on cycles where count < active_value. This gives active_value high cycles per period, starting on the period_start_o cycle.
  - Output timing: pwm_o and period_start_o are registered, aligned to the same cycle as count.
- Load handling in RUN/DRAIN:
  - load_i when count≠PERIOD_VALUE-1: value goes to the pending register and pending_o=1 from the next cycle.
  - A further load while pending overwrites the pending register; last value wins.
  - At wrap (transition into count=0): if pending, active ← pending and pending_o ← 0.
  - load_i on the wrap cycle itself (count=PERIOD_VALUE-1): the new value goes directly into active for the starting period. It also supersedes any pending value, and pending_o ← 0.
- DRAIN:
  - enable_i=0 in RUN → DRAIN next cycle; the waveform continues unchanged.
  - enable_i=1 again during DRAIN → RUN with no glitch and no count reset.
  - At wrap with enable_i still 0 → IDLE: pwm_o=0, count=0, no period_start_o pulse.
  - A pending value is still transferred to active at that boundary.
- running_o=1 in RUN/DRAIN, 0 in IDLE.
- Width/arithmetic:
  - count and comparisons are unsigned, CW bits.
  - The count never reaches PERIOD_VALUE.

Test Plan (PERIOD_VALUE=10, RESET_ON_VALUE=5 unless noted):
- Reset then enable_i=1 held → period_start_o every 10 cycles; pwm_o high 5 cycles, low 5 cycles per period; active_value_o=5.
- In RUN, load 3 at count=4 → pending_o=1 from the next cycle. The current period still gives 5 high cycles. The next period gives 3 high cycles, and pending_o clears at its period_start_o.
- Load 7 then load 2 within one period → only 2 applied at the next boundary. Load 8 exactly at count=9 → the following period is 8 high cycles; pending_o stays 0.
- Load 0 → pwm_o constant 0 while period_start_o keeps pulsing. Load 15 → stored 10, pwm_o constant 1 across boundaries.
- Drop enable_i at count=2 → period finishes (pwm_o high through count=4), then IDLE with running_o=0 at wrap. Repeat, but re-raise enable_i at count=6 → continuous waveform, no missing period_start_o.
- Assert reset_i mid-high-phase → pwm_o falls without waiting for a clock edge; active_value_o=5; pending cleared. A load in IDLE updates active_value_o the next cycle.
